// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory bus with ack timeout and fetch kill.
// Optional round-robin fairness between the ports is enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_XFER  = 2'd1,
    MEM_XFER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
`ifdef ARB_FAIRNESS_EN
  logic        last_mem_q, last_mem_d;
`endif

  logic xfer, at_limit, timeout, done;
  logic if_pend, pick_if, pick_mem;
  logic if_done, mem_done;

  assign xfer     = (state_q != IDLE);
  assign at_limit = (cnt_q == 8'(TIMEOUT));
  assign timeout  = xfer & at_limit & ~bus_ack;
  assign done     = xfer & (bus_ack | timeout);

  // A killed fetch can never be granted; a fetch only beats a data request when fairness says so.
  assign if_pend = if_req & ~if_kill;
`ifdef ARB_FAIRNESS_EN
  assign pick_if = if_pend & (~mem_req | last_mem_q);
`else
  assign pick_if = if_pend & ~mem_req;
`endif
  assign pick_mem = mem_req & ~pick_if;

  assign if_done  = (state_q == IF_XFER) & done & ~rst & ~kill_q & ~if_kill;
  assign mem_done = (state_q == MEM_XFER) & done & ~rst;

  assign if_ready  = if_done;
  assign mem_ready = mem_done;
  assign if_rdata  = (if_done & ~timeout) ? bus_rdata : 32'h0;
  assign mem_rdata = (mem_done & ~timeout) ? bus_rdata : 32'h0;
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

  assign bus_valid = xfer & ~timeout;
  assign bus_err   = timeout & ~rst;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
`ifdef ARB_FAIRNESS_EN
    last_mem_d  = last_mem_q;
`endif
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (pick_mem) begin
          state_d     = MEM_XFER;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_be_d    = mem_be;
          cnt_d       = 8'd0;
`ifdef ARB_FAIRNESS_EN
          last_mem_d  = 1'b1;
`endif
        end else if (pick_if) begin
          state_d     = IF_XFER;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = 32'h0;
          bus_be_d    = 4'hF;
          cnt_d       = 8'd0;
`ifdef ARB_FAIRNESS_EN
          last_mem_d  = 1'b0;
`endif
        end
      end
      IF_XFER: begin
        cnt_d = cnt_q + 8'd1;
        if (if_kill) kill_d = 1'b1;
        if (done) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      MEM_XFER: begin
        cnt_d = cnt_q + 8'd1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      cnt_q       <= 8'd0;
      kill_q      <= 1'b0;
`ifdef ARB_FAIRNESS_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
`ifdef ARB_FAIRNESS_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 15, bus cycles to wait for bus_ack before abort (1..255).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: if_req in 1 fetch request; if_addr in 32 fetch address; if_kill in 1 cancel fetch (from IF/ID flush).
REQ-005 SHALL have ports: if_rdata out 32; if_ready out 1 fetch complete; if_stall out 1 stall to PC/IF.
REQ-006 SHALL have ports: mem_req in 1 data request; mem_we in 1; mem_addr in 32; mem_wdata in 32; mem_be in 4.
REQ-007 SHALL have ports: mem_rdata out 32; mem_ready out 1 data complete; mem_stall out 1 stall to MEM stage.
REQ-008 SHALL have ports: bus_valid out 1; bus_we out 1; bus_addr out 32; bus_wdata out 32; bus_be out 4; bus_ack in 1; bus_rdata in 32; bus_err out 1.

Function
REQ-009 SHALL implement FSM states IDLE, IF_XFER, MEM_XFER; one bus transaction outstanding at most.
REQ-010 SHALL, in IDLE, grant one pending request, latch its address/we/wdata/be into bus_* registers, and enter the matching XFER state next edge.
REQ-011 SHALL treat fetches as reads: bus_we=0, bus_be=4'hF.
REQ-012 SHALL give mem_req priority over if_req when both are pending in IDLE (default arbitration).
REQ-013 SHALL hold bus_valid=1 and bus_* stable for every cycle in an XFER state, 0 in IDLE.
REQ-014 SHALL, on bus_ack in an XFER state, pass bus_rdata to the granted port's rdata and assert its ready combinationally that cycle, then return to IDLE.
REQ-015 SHALL give minimum latency of 2 cycles: request in IDLE at cycle N, bus_valid at N+1, ready at N+1 if bus_ack at N+1.
REQ-016 SHALL drive if_stall = if_req & ~if_ready and mem_stall = mem_req & ~mem_ready.
REQ-017 SHALL keep rdata outputs at 32'h0 when the corresponding ready is 0.
REQ-018 SHALL count XFER cycles in an 8-bit counter cleared on XFER entry; when count reaches TIMEOUT with no bus_ack: deassert bus_valid, pulse bus_err 1 cycle, assert granted ready with rdata 32'h0, return to IDLE.
REQ-019 SHALL not grant if_req in an IDLE cycle where if_kill=1.
REQ-020 SHALL, on if_kill in IF_XFER (including the bus_ack cycle), set a kill flag; the transfer completes on the bus but if_ready stays 0; flag clears on IDLE entry.
REQ-021 SHALL ignore if_kill for MEM_XFER.
REQ-022 SHALL allow back-to-back grants: a request still high in the IDLE cycle after ready is a new request.

Reset
REQ-023 SHALL on rst force state IDLE, bus_valid=0, bus_we=0, bus_addr/bus_wdata=0, bus_be=0, bus_err=0, counter=0, kill flag=0, last-grant=IF.
REQ-024 SHALL abandon any transfer in progress on rst; bus_valid low the cycle after rst sampled; no ready pulse for the abandoned transfer.
REQ-025 SHALL keep if_ready, mem_ready, stalls deasserted... stalls follow REQ-016 during reset.

Configuration
REQ-026 SHALL support macro ARB_FAIRNESS_EN: when defined, a last-grant register records the last served port; with both pending in IDLE and last grant = MEM, fetch wins; otherwise mem wins.
REQ-027 SHALL, without ARB_FAIRNESS_EN, use fixed mem priority and contain no last-grant register.

Verification
REQ-028 SHALL test single fetch: if_req=1 addr 0x100, bus_ack at 1st XFER cycle, bus_rdata 0x00500093 -> if_ready and if_rdata=0x00500093 cycle N+1, if_stall low thereafter.
REQ-029 SHALL test contention: if_req and mem_req (we=1, addr 0x2000, wdata 0xDEADBEEF, be 4'hF) same cycle -> mem served first; fetch served next; with ARB_FAIRNESS_EN two consecutive double-requests alternate MEM, IF.
REQ-030 SHALL test timeout: TIMEOUT=4, bus_ack never asserted -> bus_valid high 4 cycles, bus_err pulse, mem_ready=1 with mem_rdata=0.
REQ-031 SHALL test kill: if_kill pulse during IF_XFER with 3-cycle ack delay -> bus completes, if_ready never asserted, next if_req granted normally.
REQ-032 SHALL test reset mid-transfer: rst during MEM_XFER -> bus_valid 0 next cycle, state IDLE, no mem_ready pulse.
